// File: rtl/countdown_pkg.sv
// +--------------------------------------------------------------------------+
// | countdown_pkg: shared state encoding and default timing constants for    |
// | the countdown timer controller.                        Revision: 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

package countdown_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4
  } ctrl_state_t;

  localparam int unsigned DIV_DEFAULT      = 4;
  localparam int unsigned DONE_CYC_DEFAULT = 3;

endpackage

`default_nettype wire

// File: rtl/countdown_ctrl_tick_gen.sv
// +--------------------------------------------------------------------------+
// | tick_gen: prescaler with clear/run/hold; tick is high while the count    |
// | sits at DIV-1, where it also wraps to 0.               Revision: 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic run_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int unsigned   PW   = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  always_comb begin
    presc_d = presc_q;
    if (clear_i) begin
      presc_d = '0;
    end else if (run_i && !hold_i) begin
      presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick_o = (presc_q == LAST);

endmodule

`default_nettype wire

// File: rtl/countdown_ctrl.sv
// +--------------------------------------------------------------------------+
// | countdown_ctrl: sequences load / prescaled decrement / done pulse for a  |
// | down counter. Optional pause via COUNTDOWN_CTRL_PAUSE_EN. Revision: 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned DIV      = DIV_DEFAULT,
  parameter int unsigned DONE_CYC = DONE_CYC_DEFAULT
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          pause_i,
  input  logic [DW-1:0] count_i,
  output logic          cnt_reset_o,
  output logic          cnt_ena_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned    DCW       = (DONE_CYC > 1) ? $clog2(DONE_CYC) : 1;
  localparam logic [DCW-1:0] DONE_LAST = DCW'(DONE_CYC - 1);

  ctrl_state_t    state_q, state_d;
  logic [DCW-1:0] done_cnt_q, done_cnt_d;
  logic           start_q;
  logic           rise;
  logic           tick;
  logic           tg_clear, tg_run, tg_hold;
  logic           cnt_reset_d, cnt_ena_d, busy_d, done_d;

  assign rise = start_i & ~start_q;

  always_comb begin
    state_d    = state_q;
    done_cnt_d = '0;
    case (state_q)
      IDLE: if (rise) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN: begin
        if (rise) begin
          state_d = LOAD;
        end else if (count_i == '0) begin
          state_d = DONE;
        end
`ifdef COUNTDOWN_CTRL_PAUSE_EN
        else if (pause_i) begin
          state_d = PAUSED;
        end
`endif
      end
`ifdef COUNTDOWN_CTRL_PAUSE_EN
      PAUSED: begin
        if (rise) begin
          state_d = LOAD;
        end else if (!pause_i) begin
          state_d = RUN;
        end
      end
`endif
      DONE: begin
        if (done_cnt_q == DONE_LAST) begin
          state_d = IDLE;
        end else begin
          done_cnt_d = done_cnt_q + DCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // LOAD already advances the prescaler (0 -> 1), so the first enable
  // lands DIV cycles after the start edge and run length is 2 + N*DIV.
  always_comb begin
    tg_clear = (state_d == IDLE) || (state_d == LOAD) || (state_d == DONE);
    tg_run   = (state_q == LOAD) || (state_q == RUN);
`ifdef COUNTDOWN_CTRL_PAUSE_EN
    tg_hold  = (state_d == PAUSED) || (state_q == PAUSED);
`else
    tg_hold  = 1'b0;
`endif
  end

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (tg_clear),
    .run_i   (tg_run),
    .hold_i  (tg_hold),
    .tick_o  (tick)
  );

  always_comb begin
    cnt_reset_d = (state_d == LOAD);
    cnt_ena_d   = (state_q == RUN) && (state_d == RUN) && tick && (count_i != '0);
    busy_d      = (state_d == LOAD) || (state_d == RUN) || (state_d == PAUSED);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      done_cnt_q  <= '0;
      cnt_reset_o <= 1'b0;
      cnt_ena_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_i;
      done_cnt_q  <= done_cnt_d;
      cnt_reset_o <= cnt_reset_d;
      cnt_ena_o   <= cnt_ena_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
    end
  end

`ifndef COUNTDOWN_CTRL_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause_i;
`endif

endmodule

`default_nettype wire
